// File: rtl/buffer_bank_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buffer_bank_sequencer_pkg: default sizes and sequencer state codes.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package buffer_bank_sequencer_pkg;

  localparam int DEF_ARRAY_SIZE = 9;
  localparam int DEF_DATA_SIZE  = 16;
  localparam int DEF_ADDR_W     = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/buffer_bank_sequencer_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bank_ram: simple dual-port read-first RAM, 1-cycle registered read.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bank_ram #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_W    = 14
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  logic [DATA_SIZE-1:0] mem_q [2**ADDR_W];
  logic [DATA_SIZE-1:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/buffer_bank_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buffer_bank_sequencer: banked buffer RAM with aligned/skewed burst   |
// | read sequencer feeding one output lane per bank.  Rev 1.0            |
// +----------------------------------------------------------------------+
module buffer_bank_sequencer
  import buffer_bank_sequencer_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ARRAY_SIZE-1:0]           wea,
  input  logic [ARRAY_SIZE*ADDR_W-1:0]    addra,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0] dina,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [ADDR_W:0]                 rd_len,
  input  logic                            skew_en,
  output logic                            busy,
  output logic                            done,
  output logic [ARRAY_SIZE-1:0]           out_valid,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] bus2
);

  localparam int SKEW_DEPTH = (ARRAY_SIZE > 1) ? ARRAY_SIZE - 1 : 1;
  localparam int DRAIN_W    = $clog2(ARRAY_SIZE + 1);
  localparam logic [DRAIN_W-1:0] SKEW_DRAIN = DRAIN_W'(ARRAY_SIZE - 1);
  localparam logic [ADDR_W:0]    LEN_ONE    = (ADDR_W+1)'(1);

  seq_state_t           state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 skew_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W:0]      rem_q;
  logic [DRAIN_W-1:0]   drain_q;
  logic                 issue_en;

  logic [SKEW_DEPTH-1:0]           chain_en_q;
  logic [ADDR_W-1:0]               chain_addr_q [SKEW_DEPTH];
  logic [ARRAY_SIZE-1:0]           lane_en;
  logic [ADDR_W-1:0]               lane_addr [ARRAY_SIZE];
  logic [DATA_SIZE-1:0]            ram_dout [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]           rvalid_q;
  logic [ARRAY_SIZE-1:0]           out_valid_q;
  logic [ARRAY_SIZE*DATA_SIZE-1:0] bus2_q;

  assign issue_en = (state_q == ST_RUN);

  // DRAIN covers the skew depth; the final RAM+output register latency is
  // absorbed by done itself being a registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      skew_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      drain_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start && !busy_q) begin
            if (rd_len != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              addr_q  <= base_addr;
              rem_q   <= rd_len;
              skew_q  <= skew_en;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == LEN_ONE) begin
            state_q <= ST_DRAIN;
            drain_q <= skew_q ? SKEW_DRAIN : '0;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // One shared tapped delay line: tap j carries the issue delayed j+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_en_q  <= '0;
      rvalid_q    <= '0;
      out_valid_q <= '0;
      bus2_q      <= '0;
      for (int j = 0; j < SKEW_DEPTH; j++) begin
        chain_addr_q[j] <= '0;
      end
    end else begin
      chain_en_q[0]   <= issue_en;
      chain_addr_q[0] <= addr_q;
      for (int j = 1; j < SKEW_DEPTH; j++) begin
        chain_en_q[j]   <= chain_en_q[j-1];
        chain_addr_q[j] <= chain_addr_q[j-1];
      end
      rvalid_q    <= lane_en;
      out_valid_q <= rvalid_q;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        if (rvalid_q[i]) begin
          bus2_q[i*DATA_SIZE +: DATA_SIZE] <= ram_dout[i];
        end
      end
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign lane_en[i]   = issue_en;
      assign lane_addr[i] = addr_q;
    end else begin : g_skewed
      assign lane_en[i]   = skew_q ? chain_en_q[i-1]   : issue_en;
      assign lane_addr[i] = skew_q ? chain_addr_q[i-1] : addr_q;
    end

    bank_ram #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (wea[i]),
      .waddr_i (addra[i*ADDR_W +: ADDR_W]),
      .wdata_i (dina[i*DATA_SIZE +: DATA_SIZE]),
      .re_i    (lane_en[i]),
      .raddr_i (lane_addr[i]),
      .rdata_o (ram_dout[i])
    );
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign bus2      = bus2_q;

endmodule
`default_nettype wire

// File: tb/tb_buffer_bank_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_buffer_bank_sequencer: directed bench, 3 banks x 16 words x 16b.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_buffer_bank_sequencer;

  localparam int AS    = 3;
  localparam int DS    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [AS-1:0]     wea;
  logic [AS*AW-1:0]  addra;
  logic [AS*DS-1:0]  dina;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       rd_len;
  logic              skew_en;
  logic              busy;
  logic              done;
  logic [AS-1:0]     out_valid;
  logic [AS*DS-1:0]  bus2;

  int checks = 0;
  int errors = 0;

  logic [DS-1:0] model   [AS][DEPTH];
  logic [DS-1:0] exp_bus [AS];

  buffer_bank_sequencer #(
    .ARRAY_SIZE (AS),
    .DATA_SIZE  (DS),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .start     (start),
    .base_addr (base_addr),
    .rd_len    (rd_len),
    .skew_en   (skew_en),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .bus2      (bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
    check({tag, " out_valid"}, 64'(out_valid), 64'(0));
    check({tag, " bus2"}, 64'(bus2), 64'(0));
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < DEPTH; a++) begin
      wea = '1;
      for (int i = 0; i < AS; i++) begin
        addra[i*AW +: AW] = AW'(a);
        dina[i*DS +: DS]  = {4'(i), 12'(a)};
        model[i][a]       = {4'(i), 12'(a)};
      end
      step();
    end
    wea = '0;
  endtask

  task automatic random_writes(input int n);
    int b;
    logic [AW-1:0] a;
    logic [DS-1:0] d;
    for (int w = 0; w < n; w++) begin
      b = int'($urandom_range(AS - 1));
      a = AW'($urandom_range(DEPTH - 1));
      d = DS'($urandom);
      wea = '0;
      wea[b] = 1'b1;
      addra[b*AW +: AW] = a;
      dina[b*DS +: DS]  = d;
      model[b][a] = d;
      step();
    end
    wea = '0;
  endtask

  // Issues one burst and checks every lane/status cycle from the start edge
  // until one cycle after done. Optional same-cycle write (applied to the
  // model only afterwards) and an extra start request one cycle in.
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len, input logic skew,
                           input bit inj_wr, input int inj_bank, input logic [AW-1:0] inj_addr,
                           input logic [DS-1:0] inj_data, input bit inj_start);
    int dmax, last, k, d;
    logic ebusy, edone, ev;
    dmax = skew ? AS - 1 : 0;
    last = (len == 0) ? 1 : int'(len) + dmax + 2;
    start     = 1'b1;
    base_addr = base;
    rd_len    = len;
    skew_en   = skew;
    for (int m = 0; m <= last; m++) begin
      step();
      start = 1'b0;
      wea   = '0;
      if (m == 0 && inj_start) begin
        start     = 1'b1;
        base_addr = base + 4'd7;
        rd_len    = 5'd2;
        skew_en   = ~skew;
      end
      if (m == 0 && inj_wr) begin
        wea[inj_bank] = 1'b1;
        addra[inj_bank*AW +: AW] = inj_addr;
        dina[inj_bank*DS +: DS]  = inj_data;
      end
      if (len == 0) begin
        ebusy = 1'b0;
        edone = (m == 0);
      end else begin
        ebusy = (m <= 1 + int'(len) + dmax);
        edone = (m == 1 + int'(len) + dmax);
      end
      check($sformatf("b%0d/l%0d/s%0d m%0d busy", base, len, skew, m), 64'(busy), 64'(ebusy));
      check($sformatf("b%0d/l%0d/s%0d m%0d done", base, len, skew, m), 64'(done), 64'(edone));
      for (int i = 0; i < AS; i++) begin
        d  = skew ? i : 0;
        k  = m - 2 - d;
        ev = (len != 0) && (k >= 0) && (k < int'(len));
        if (ev) exp_bus[i] = model[i][(int'(base) + k) % DEPTH];
        check($sformatf("b%0d/l%0d/s%0d m%0d lane%0d valid", base, len, skew, m, i),
              64'(out_valid[i]), 64'(ev));
        check($sformatf("b%0d/l%0d/s%0d m%0d lane%0d data", base, len, skew, m, i),
              64'(bus2[i*DS +: DS]), 64'(exp_bus[i]));
      end
    end
    wea = '0;
    if (inj_wr) model[inj_bank][inj_addr] = inj_data;
  endtask

  initial begin
    logic [AW-1:0] rb;
    logic [AW:0]   rl;
    logic          rs;

    rst = 1'b1; start = 1'b0; base_addr = '0; rd_len = '0; skew_en = 1'b0;
    wea = '0; addra = '0; dina = '0;
    for (int i = 0; i < AS; i++) exp_bus[i] = '0;
    repeat (2) step();
    check_idle_zero("reset");
    rst = 1'b0;

    fill_pattern();
    run_burst(4'd2, 5'd4, 1'b0, 0, 0, '0, '0, 0);
    run_burst(4'd2, 5'd4, 1'b1, 0, 0, '0, '0, 0);
    run_burst(4'd14, 5'd4, 1'b0, 0, 0, '0, '0, 0);
    run_burst(4'd14, 5'd4, 1'b1, 0, 0, '0, '0, 0);
    run_burst(4'd3, 5'd0, 1'b0, 0, 0, '0, '0, 0);
    run_burst(4'd0, 5'd3, 1'b1, 0, 0, '0, '0, 1);

    // Abort a skewed burst while it is still issuing reads.
    start = 1'b1; base_addr = 4'd0; rd_len = 5'd8; skew_en = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < AS; i++) exp_bus[i] = '0;
    check_idle_zero("abort");
    for (int c = 0; c < 12; c++) begin
      step();
      check($sformatf("post-abort c%0d done", c), 64'(done), 64'(0));
      check($sformatf("post-abort c%0d out_valid", c), 64'(out_valid), 64'(0));
    end
    run_burst(4'd9, 5'd3, 1'b1, 0, 0, '0, '0, 0);

    run_burst(4'd5, 5'd1, 1'b0, 1, 1, 4'd5, 16'hBEEF, 0);
    run_burst(4'd5, 5'd1, 1'b0, 0, 0, '0, '0, 0);

    for (int r = 0; r < 5; r++) begin
      random_writes(12);
      rb = AW'($urandom_range(DEPTH - 1));
      rl = (AW+1)'($urandom_range(DEPTH));
      rs = 1'($urandom_range(1));
      run_burst(rb, rl, rs, 0, 0, '0, '0, 0);
    end
    run_burst(4'd7, 5'd16, 1'b1, 0, 0, '0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
